// File: rtl/spine_pkg.sv
// Shared types and constants for the spine router.
// Latency: none; this is a package of declarations only.
// Backpressure: not applicable.
//
// Holds the address layout of a flit (6-bit destination, group in [5:2]),
// the flit struct at the default data width and the group-extract helper.
package spine_pkg;

  localparam int ADDR_W         = 6;
  localparam int GROUP_MSB      = 5;
  localparam int GROUP_LSB      = 2;
  localparam int GROUP_W        = GROUP_MSB - GROUP_LSB + 1;
  localparam int NUM_LEAVES_MAX = 4;
  localparam int FLIT_DWIDTH    = 16;

  typedef struct packed {
    logic [ADDR_W-1:0]      dest;
    logic [FLIT_DWIDTH-1:0] data;
  } flit_t;

  // Destination group selects the spine output (leaf port) for a flit.
  function automatic logic [GROUP_W-1:0] dest_group(input logic [ADDR_W-1:0] dest);
    return dest[GROUP_MSB:GROUP_LSB];
  endfunction

endpackage

// File: rtl/spine_rr_arbiter.sv
// Round-robin arbiter for one spine output: picks the first requester at or after ptr.
// Latency: purely combinational, grant in the same cycle as the requests.
// Backpressure: the caller gates req_vld when the output cannot issue; no grant then.
//
// Ports: req_vld (one bit per input), ptr (current priority start),
//        gnt (one-hot grant), gnt_vld (any grant), nxt_ptr (granted index + 1 mod N).
module spine_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_vld,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          gnt_vld,
  output logic [PW-1:0] nxt_ptr
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    nxt_ptr = ptr;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_vld && req_vld[idx]) begin
        gnt[idx] = 1'b1;
        gnt_vld  = 1'b1;
        nxt_ptr  = PW'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/spine_router.sv
// Spine switch: per-port input FIFOs, destination-group routing, round-robin per output.
// Latency: a flit presented at edge N is written at N+1 and registered on leaf_out at N+2.
// Backpressure: output holds while leaf_out_ready=0; inputs never stall, full FIFO drops.
//
// Ports: clk, reset (async active-low); leaf_in_{data,valid,dest_addr}, leaf_in_ready;
//        leaf_out_{data,valid,dest_addr}, leaf_out_ready; in_fifo_full/empty,
//        drop_count (saturating 8-bit), busy, fwd_count (16-bit per output).
// Optional: define SPINE_FWD_COUNT_EN to build the per-output forwarded-flit counters;
//           otherwise fwd_count is constant zero.
module spine_router
  import spine_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_LEAVES = 4,
  parameter int SPINE_ID   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_LEAVES*DWIDTH-1:0] leaf_in_data,
  input  logic [NUM_LEAVES-1:0]        leaf_in_valid,
  input  logic [NUM_LEAVES*ADDR_W-1:0] leaf_in_dest_addr,
  output logic [NUM_LEAVES-1:0]        leaf_in_ready,
  output logic [NUM_LEAVES*DWIDTH-1:0] leaf_out_data,
  output logic [NUM_LEAVES-1:0]        leaf_out_valid,
  output logic [NUM_LEAVES*ADDR_W-1:0] leaf_out_dest_addr,
  input  logic [NUM_LEAVES-1:0]        leaf_out_ready,
  output logic [NUM_LEAVES-1:0]        in_fifo_full,
  output logic [NUM_LEAVES-1:0]        in_fifo_empty,
  output logic [7:0]                   drop_count,
  output logic                         busy,
  output logic [NUM_LEAVES*16-1:0]     fwd_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int PW  = $clog2(NUM_LEAVES);
  localparam int DCW = $clog2(NUM_LEAVES + 1);
  localparam logic [GROUP_W-1:0] NUM_GROUPS = GROUP_W'(NUM_LEAVES);

  if (NUM_LEAVES != NUM_LEAVES_MAX || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SPINE_ID < 0) begin : g_cfg_check
    $error("spine_router: unsupported configuration");
  end

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DWIDTH-1:0] data;
  } flit_dw_t;

  flit_dw_t mem_q [NUM_LEAVES][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q [NUM_LEAVES];
  logic [AW-1:0] wr_ptr_d [NUM_LEAVES];
  logic [AW-1:0] rd_ptr_q [NUM_LEAVES];
  logic [AW-1:0] rd_ptr_d [NUM_LEAVES];
  logic [CW-1:0] cnt_q    [NUM_LEAVES];
  logic [CW-1:0] cnt_d    [NUM_LEAVES];

  flit_dw_t in_flit   [NUM_LEAVES];
  flit_dw_t head_flit [NUM_LEAVES];
  logic [NUM_LEAVES-1:0] full, empty, legal, push, drop, pop;

  logic [NUM_LEAVES-1:0] req [NUM_LEAVES];  // req[o][i]: input i wants output o
  logic [NUM_LEAVES-1:0] gnt [NUM_LEAVES];  // gnt[o][i]
  logic [NUM_LEAVES-1:0] gnt_any, can_issue;
  logic [PW-1:0] rr_ptr_q [NUM_LEAVES];
  logic [PW-1:0] rr_ptr_d [NUM_LEAVES];
  logic [PW-1:0] rr_nxt   [NUM_LEAVES];

  flit_dw_t out_flit_q [NUM_LEAVES];
  flit_dw_t out_flit_d [NUM_LEAVES];
  logic [NUM_LEAVES-1:0] out_vld_q, out_vld_d;

  logic [7:0]     drop_count_q, drop_count_d;
  logic [DCW-1:0] ndrop;
  logic [8:0]     drop_sum;

  // Input side: full is judged on the registered count, before any pop this cycle,
  // so a full FIFO drops even if its head leaves in the same cycle.
  for (genvar i = 0; i < NUM_LEAVES; i++) begin : g_in
    assign in_flit[i]   = {leaf_in_dest_addr[i*ADDR_W +: ADDR_W], leaf_in_data[i*DWIDTH +: DWIDTH]};
    assign full[i]      = (cnt_q[i] == CW'(FIFO_DEPTH));
    assign empty[i]     = (cnt_q[i] == '0);
    assign legal[i]     = (dest_group(in_flit[i].dest) < NUM_GROUPS);
    assign push[i]      = leaf_in_valid[i] & legal[i] & ~full[i];
    assign drop[i]      = leaf_in_valid[i] & ~(legal[i] & ~full[i]);
    assign head_flit[i] = mem_q[i][rd_ptr_q[i]];
  end

  // Only legal groups are ever enqueued, so every head maps to exactly one output.
  for (genvar o = 0; o < NUM_LEAVES; o++) begin : g_out
    assign can_issue[o] = ~out_vld_q[o] | leaf_out_ready[o];
    for (genvar i = 0; i < NUM_LEAVES; i++) begin : g_req
      assign req[o][i] = ~empty[i] & can_issue[o] &
                         (dest_group(head_flit[i].dest) == GROUP_W'(o));
    end
    spine_rr_arbiter #(.N(NUM_LEAVES), .PW(PW)) u_arb (
      .req_vld (req[o]),
      .ptr     (rr_ptr_q[o]),
      .gnt     (gnt[o]),
      .gnt_vld (gnt_any[o]),
      .nxt_ptr (rr_nxt[o])
    );
    assign leaf_out_data[o*DWIDTH +: DWIDTH]      = out_flit_q[o].data;
    assign leaf_out_dest_addr[o*ADDR_W +: ADDR_W] = out_flit_q[o].dest;
  end

  always_comb begin
    pop = '0;
    for (int o = 0; o < NUM_LEAVES; o++) begin
      pop = pop | gnt[o];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LEAVES; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop[i]);
      cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_LEAVES; o++) begin
      out_vld_d[o]  = out_vld_q[o];
      out_flit_d[o] = out_flit_q[o];
      rr_ptr_d[o]   = rr_ptr_q[o];
      if (gnt_any[o]) begin
        out_vld_d[o]  = 1'b1;
        rr_ptr_d[o]   = rr_nxt[o];
        out_flit_d[o] = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
          if (gnt[o][i]) out_flit_d[o] = head_flit[i];
        end
      end else if (leaf_out_ready[o]) begin
        out_vld_d[o] = 1'b0;
      end
    end
  end

  // Drops from several ports in one cycle add up before saturating.
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NUM_LEAVES; i++) begin
      ndrop = ndrop + DCW'(drop[i]);
    end
    drop_sum     = {1'b0, drop_count_q} + 9'(ndrop);
    drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Storage array carries no reset: the counts alone define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LEAVES; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_flit[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LEAVES; i++) begin
        wr_ptr_q[i]   <= '0;
        rd_ptr_q[i]   <= '0;
        cnt_q[i]      <= '0;
        rr_ptr_q[i]   <= '0;
        out_flit_q[i] <= '0;
      end
      out_vld_q    <= '0;
      drop_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LEAVES; i++) begin
        wr_ptr_q[i]   <= wr_ptr_d[i];
        rd_ptr_q[i]   <= rd_ptr_d[i];
        cnt_q[i]      <= cnt_d[i];
        rr_ptr_q[i]   <= rr_ptr_d[i];
        out_flit_q[i] <= out_flit_d[i];
      end
      out_vld_q    <= out_vld_d;
      drop_count_q <= drop_count_d;
    end
  end

`ifdef SPINE_FWD_COUNT_EN
  logic [15:0] fwd_cnt_q [NUM_LEAVES];
  logic [15:0] fwd_cnt_d [NUM_LEAVES];

  always_comb begin
    for (int o = 0; o < NUM_LEAVES; o++) begin
      fwd_cnt_d[o] = fwd_cnt_q[o];
      if (gnt_any[o] && (fwd_cnt_q[o] != 16'hFFFF)) fwd_cnt_d[o] = fwd_cnt_q[o] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < NUM_LEAVES; o++) fwd_cnt_q[o] <= '0;
    end else begin
      for (int o = 0; o < NUM_LEAVES; o++) fwd_cnt_q[o] <= fwd_cnt_d[o];
    end
  end

  for (genvar o = 0; o < NUM_LEAVES; o++) begin : g_fwd
    assign fwd_count[o*16 +: 16] = fwd_cnt_q[o];
  end
`else
  assign fwd_count = '0;
`endif

  assign leaf_in_ready  = ~full;
  assign in_fifo_full   = full;
  assign in_fifo_empty  = empty;
  assign leaf_out_valid = out_vld_q;
  assign drop_count     = drop_count_q;
  assign busy           = (|(~empty)) | (|out_vld_q);

endmodule

// File: tb/tb_spine_router.sv
`timescale 1ns/1ps
module tb_spine_router;
  import spine_pkg::*;

  localparam int NL = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  logic [NL*DW-1:0] leaf_in_data;
  logic [NL-1:0]    leaf_in_valid;
  logic [NL*6-1:0]  leaf_in_dest_addr;
  logic [NL-1:0]    leaf_in_ready;
  logic [NL*DW-1:0] leaf_out_data;
  logic [NL-1:0]    leaf_out_valid;
  logic [NL*6-1:0]  leaf_out_dest_addr;
  logic [NL-1:0]    leaf_out_ready;
  logic [NL-1:0]    in_fifo_full;
  logic [NL-1:0]    in_fifo_empty;
  logic [7:0]       drop_count;
  logic             busy;
  logic [NL*16-1:0] fwd_count;

  always #5 clk = ~clk;

  spine_router #(.DWIDTH(DW), .FIFO_DEPTH(8), .NUM_LEAVES(NL), .SPINE_ID(1)) dut (
    .clk                (clk),
    .reset              (reset),
    .leaf_in_data       (leaf_in_data),
    .leaf_in_valid      (leaf_in_valid),
    .leaf_in_dest_addr  (leaf_in_dest_addr),
    .leaf_in_ready      (leaf_in_ready),
    .leaf_out_data      (leaf_out_data),
    .leaf_out_valid     (leaf_out_valid),
    .leaf_out_dest_addr (leaf_out_dest_addr),
    .leaf_out_ready     (leaf_out_ready),
    .in_fifo_full       (in_fifo_full),
    .in_fifo_empty      (in_fifo_empty),
    .drop_count         (drop_count),
    .busy               (busy),
    .fwd_count          (fwd_count)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  flit_t exp_q [NL][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int p, input logic [5:0] d, input logic [15:0] dat);
    leaf_in_valid[p]           = 1'b1;
    leaf_in_dest_addr[p*6 +: 6] = d;
    leaf_in_data[p*DW +: DW]    = dat;
  endtask

  task automatic expect_flit(input int o, input logic [5:0] d, input logic [15:0] dat);
    exp_q[o].push_back({d, dat});
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check({name, "_drain"}, 64'(busy), 64'd0);
    tick();
  endtask

  // Monitor: every accepted output flit is matched against the per-output queue.
  initial begin : monitor
    flit_t got, e;
    forever begin
      @(negedge clk);
      for (int o = 0; o < NL; o++) begin
        if (reset === 1'b1 && leaf_out_valid[o] === 1'b1 && leaf_out_ready[o] === 1'b1) begin
          got.dest = leaf_out_dest_addr[o*6 +: 6];
          got.data = leaf_out_data[o*DW +: DW];
          if (exp_q[o].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out%0d: got 0x%0h, expected no flit", o, got);
          end else begin
            e = exp_q[o].pop_front();
            check($sformatf("out%0d_flit", o), 64'(got), 64'(e));
          end
        end
      end
    end
  end

  initial begin : stim
    int left;
    reset             = 1'b0;
    leaf_in_valid     = '0;
    leaf_in_data      = '0;
    leaf_in_dest_addr = '0;
    leaf_out_ready    = '1;

    // Reset values
    #12;
    check("rst_in_ready",  64'(leaf_in_ready),      64'hF);
    check("rst_empty",     64'(in_fifo_empty),      64'hF);
    check("rst_full",      64'(in_fifo_full),       64'h0);
    check("rst_out_valid", 64'(leaf_out_valid),     64'h0);
    check("rst_out_data",  64'(leaf_out_data),      64'h0);
    check("rst_out_dest",  64'(leaf_out_dest_addr), 64'h0);
    check("rst_drop",      64'(drop_count),         64'h0);
    check("rst_busy",      64'(busy),               64'h0);
    check("rst_fwd",       64'(fwd_count),          64'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    // Latency: flit presented at edge N, FIFO at N+1, on leaf_out[2] at N+2
    set_in(0, 6'b001000, 16'hA5A5);
    expect_flit(2, 6'b001000, 16'hA5A5);
    tick();
    leaf_in_valid = '0;
    check("lat_n1_valid", 64'(leaf_out_valid), 64'h0);
    check("lat_n1_empty", 64'(in_fifo_empty),  64'hE);
    tick();
    check("lat_n2_valid", 64'(leaf_out_valid),           64'h4);
    check("lat_n2_data",  64'(leaf_out_data[2*DW +: DW]), 64'hA5A5);
    wait_idle("lat");

    // Contention on output 1: two rounds, order 0..3 both times
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NL; p++) begin
        set_in(p, 6'b000100, 16'(16'h1000 + p));
        expect_flit(1, 6'b000100, 16'(16'h1000 + p));
      end
      tick();
      leaf_in_valid = '0;
      for (int k = 0; k < NL; k++) begin
        tick();
        check($sformatf("cont_r%0d_cyc%0d_data", r, k), 64'(leaf_out_data[1*DW +: DW]),
              64'(16'h1000 + k));
      end
      wait_idle("cont");
    end

    // Backpressure: output 3 stalled, leaf1 sends 10 flits -> 1 held, 8 buffered, 1 dropped
    leaf_out_ready[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_in(1, 6'b001100, 16'(16'h3000 + k));
      if (k < 9) expect_flit(3, 6'b001100, 16'(16'h3000 + k));
      tick();
    end
    leaf_in_valid = '0;
    check("bp_full",      64'(in_fifo_full),               64'h2);
    check("bp_in_ready",  64'(leaf_in_ready),              64'hD);
    check("bp_drop",      64'(drop_count),                 64'd1);
    check("bp_hold_vld",  64'(leaf_out_valid),             64'h8);
    check("bp_hold_data", 64'(leaf_out_data[3*DW +: DW]),  64'h3000);
    tick();
    check("bp_hold_data2", 64'(leaf_out_data[3*DW +: DW]), 64'h3000);
    leaf_out_ready[3] = 1'b1;
    wait_idle("bp");
    check("bp_drop_after", 64'(drop_count), 64'd1);

    // Illegal group 5 on port 2: dropped, never enqueued
    set_in(2, 6'b010100, 16'hDEAD);
    tick();
    leaf_in_valid = '0;
    check("ill_empty", 64'(in_fifo_empty), 64'hF);
    check("ill_drop",  64'(drop_count),    64'd2);
    // 300 illegal flits, 4 per cycle: first cycle adds 4, then saturates at 255
    for (int p = 0; p < NL; p++) set_in(p, 6'b111100, 16'hBEEF);
    tick();
    check("ill_multi_drop", 64'(drop_count), 64'd6);
    for (int k = 1; k < 75; k++) tick();
    leaf_in_valid = '0;
    check("ill_sat", 64'(drop_count), 64'd255);
    tick();
    check("ill_busy", 64'(busy), 64'd0);

    // Five flits to output 0 (U-turn from port 0), dest low bits carried through
    for (int k = 0; k < 5; k++) begin
      set_in(0, 6'(k % 4), 16'(16'h5000 + k));
      expect_flit(0, 6'(k % 4), 16'(16'h5000 + k));
      tick();
    end
    leaf_in_valid = '0;
    wait_idle("fwd");
`ifdef SPINE_FWD_COUNT_EN
    check("fwd_count", 64'(fwd_count), 64'h0009_0001_0008_0005);
`else
    check("fwd_count", 64'(fwd_count), 64'h0);
`endif

    // Async reset with half-full FIFOs and a held output
    leaf_out_ready = '0;
    for (int k = 0; k < 5; k++) begin
      set_in(0, 6'b001000, 16'(16'h7000 + k));
      set_in(1, 6'b001000, 16'(16'h7100 + k));
      tick();
    end
    leaf_in_valid = '0;
    check("ar_pre_valid", 64'(leaf_out_valid), 64'h4);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("ar_valid", 64'(leaf_out_valid), 64'h0);
    check("ar_data",  64'(leaf_out_data),  64'h0);
    check("ar_busy",  64'(busy),           64'h0);
    check("ar_empty", 64'(in_fifo_empty),  64'hF);
    check("ar_drop",  64'(drop_count),     64'h0);
    check("ar_fwd",   64'(fwd_count),      64'h0);
    leaf_out_ready = '1;
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    check("ar_post_busy", 64'(busy), 64'h0);

    left = 0;
    for (int o = 0; o < NL; o++) left += exp_q[o].size();
    check("scoreboard_left", 64'(left), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
